// File: rtl/eth_pkg.sv
// Shared Ethernet/ARP constants, FSM encodings and field helpers for the GMII TX paths.
package eth_pkg;

    localparam logic [15:0] ETH_TYPE_ARP    = 16'h0806;
    localparam logic [15:0] ARP_HTYPE       = 16'h0001;
    localparam logic [15:0] ARP_PTYPE       = 16'h0800;
    localparam logic [15:0] ARP_OP_REQ      = 16'h0001;
    localparam logic [15:0] ARP_OP_REP      = 16'h0002;
    localparam logic [7:0]  ARP_HLEN        = 8'h06;
    localparam logic [7:0]  ARP_PLEN        = 8'h04;
    localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
    localparam logic [7:0]  SFD_BYTE        = 8'hD5;
    localparam int          ETH_MIN_PAYLOAD = 46;

    // Last byte index of each fixed-length section
    localparam logic [5:0] PRE_LAST = 6'd7;
    localparam logic [5:0] ETH_LAST = 6'd13;
    localparam logic [5:0] ARP_LAST = 6'd27;
    localparam logic [5:0] PAD_LAST = 6'(ETH_MIN_PAYLOAD - 28 - 1);
    localparam logic [5:0] FCS_LAST = 6'd3;

    typedef enum logic [6:0] {
        ST_IDLE = 7'b0000001,
        ST_PRE  = 7'b0000010,
        ST_ETH  = 7'b0000100,
        ST_ARP  = 7'b0001000,
        ST_PAD  = 7'b0010000,
        ST_FCS  = 7'b0100000,
        ST_IFG  = 7'b1000000
    } arp_state_e;

    function automatic logic [7:0] mac_byte(input logic [47:0] m, input logic [5:0] i);
        logic [47:0] s;
        s = m << {i, 3'b000};
        return s[47:40];
    endfunction

    function automatic logic [7:0] ip_byte(input logic [31:0] a, input logic [5:0] i);
        logic [31:0] s;
        s = a << {i, 3'b000};
        return s[31:24];
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide reflected CRC-32 (Ethernet FCS); crc_next exposes the value the register takes next edge.
module crc32_d8 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  data,
    input  logic        crc_en,
    input  logic        crc_clr,
    output logic [31:0] crc_data,
    output logic [31:0] crc_next
);

    logic [31:0] crc_q;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB8_8320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    always_comb begin
        crc_next = crc_q;
        if (crc_clr)     crc_next = 32'hFFFF_FFFF;
        else if (crc_en) crc_next = crc_step(crc_q, data);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) crc_q <= 32'hFFFF_FFFF;
        else        crc_q <= crc_next;
    end

    assign crc_data = crc_q;

endmodule

// File: rtl/arp_tx.sv
// ARP request/reply frame generator on GMII: preamble, header, ARP body, pad, FCS, then IFG.
module arp_tx
    import eth_pkg::*;
#(
    parameter logic [47:0] BOARD_MAC  = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP   = {8'd192, 8'd168, 8'd1, 8'd10},
    parameter int          IFG_CYCLES = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arp_tx_en,
    input  logic        arp_tx_type,
    input  logic [47:0] des_mac,
    input  logic [31:0] des_ip,
    output logic        gmii_tx_en,
    output logic [7:0]  gmii_txd,
    output logic        tx_busy,
    output logic        tx_done
);

    localparam logic [5:0] IFG_LAST = 6'(IFG_CYCLES - 1);

    arp_state_e  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        type_q;
    logic [47:0] mac_q;
    logic [31:0] ip_q;
    logic [7:0]  txd_q, byte_d;
    logic        tx_en_q, busy_q, done_q;
    logic [31:0] crc_data, crc_next, fcs;
    logic        crc_en, crc_clr;

    assign crc_clr = (state_q == ST_IDLE);
    assign crc_en  = (state_q inside {ST_ETH, ST_ARP, ST_PAD});

    crc32_d8 u_crc (
        .clk     (clk),
        .rst_n   (rst_n),
        .data    (txd_q),
        .crc_en  (crc_en),
        .crc_clr (crc_clr),
        .crc_data(crc_data),
        .crc_next(crc_next)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 6'd1;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (arp_tx_en) state_d = ST_PRE;
            end
            ST_PRE: if (cnt_q == PRE_LAST) begin state_d = ST_ETH; cnt_d = '0; end
            ST_ETH: if (cnt_q == ETH_LAST) begin state_d = ST_ARP; cnt_d = '0; end
            ST_ARP: if (cnt_q == ARP_LAST) begin state_d = ST_PAD; cnt_d = '0; end
            ST_PAD: if (cnt_q == PAD_LAST) begin state_d = ST_FCS; cnt_d = '0; end
            ST_FCS: if (cnt_q == FCS_LAST) begin state_d = ST_IFG; cnt_d = '0; end
            ST_IFG: if (cnt_q == IFG_LAST) begin state_d = ST_IDLE; cnt_d = '0; end
            default: begin state_d = ST_IDLE; cnt_d = '0; end
        endcase
    end

    // The first FCS byte is chosen while the last pad byte is still being folded in,
    // so it must come from crc_next; later FCS bytes see the settled register.
    assign fcs = ~((state_q == ST_FCS) ? crc_data : crc_next);

    // Byte for the wire next cycle, selected from the next state/count
    always_comb begin
        byte_d = 8'h00;
        unique case (state_d)
            ST_PRE: byte_d = (cnt_d == PRE_LAST) ? SFD_BYTE : PREAMBLE_BYTE;
            ST_ETH: begin
                if (cnt_d < 6'd6)       byte_d = type_q ? mac_byte(mac_q, cnt_d) : 8'hFF;
                else if (cnt_d < 6'd12) byte_d = mac_byte(BOARD_MAC, cnt_d - 6'd6);
                else                    byte_d = cnt_d[0] ? ETH_TYPE_ARP[7:0] : ETH_TYPE_ARP[15:8];
            end
            ST_ARP: begin
                if (cnt_d < 6'd2)       byte_d = cnt_d[0] ? ARP_HTYPE[7:0] : ARP_HTYPE[15:8];
                else if (cnt_d < 6'd4)  byte_d = cnt_d[0] ? ARP_PTYPE[7:0] : ARP_PTYPE[15:8];
                else if (cnt_d == 6'd4) byte_d = ARP_HLEN;
                else if (cnt_d == 6'd5) byte_d = ARP_PLEN;
                else if (cnt_d < 6'd8)  byte_d = type_q ? (cnt_d[0] ? ARP_OP_REP[7:0] : ARP_OP_REP[15:8])
                                                        : (cnt_d[0] ? ARP_OP_REQ[7:0] : ARP_OP_REQ[15:8]);
                else if (cnt_d < 6'd14) byte_d = mac_byte(BOARD_MAC, cnt_d - 6'd8);
                else if (cnt_d < 6'd18) byte_d = ip_byte(BOARD_IP, cnt_d - 6'd14);
                else if (cnt_d < 6'd24) byte_d = type_q ? mac_byte(mac_q, cnt_d - 6'd18) : 8'h00;
                else                    byte_d = ip_byte(ip_q, cnt_d - 6'd24);
            end
            ST_FCS:  byte_d = fcs[{cnt_d[1:0], 3'b000} +: 8];
            default: byte_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            type_q  <= 1'b0;
            mac_q   <= '0;
            ip_q    <= '0;
            txd_q   <= 8'h00;
            tx_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == ST_IDLE && arp_tx_en) begin
                type_q <= arp_tx_type;
                mac_q  <= des_mac;
                ip_q   <= des_ip;
            end
            txd_q   <= byte_d;
            tx_en_q <= state_d inside {ST_PRE, ST_ETH, ST_ARP, ST_PAD, ST_FCS};
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_q == ST_FCS) && (state_d == ST_IFG);
        end
    end

    assign gmii_tx_en = tx_en_q;
    assign gmii_txd   = txd_q;
    assign tx_busy    = busy_q;
    assign tx_done    = done_q;

endmodule

// File: tb/tb_arp_tx.sv
// Directed bench for arp_tx: frame contents, FCS residue, start filtering, reset and IFG timing.
module tb_arp_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arp_tx_en = 1'b0;
    logic        arp_tx_type = 1'b0;
    logic [47:0] des_mac = '0;
    logic [31:0] des_ip = '0;
    logic        gmii_tx_en;
    logic [7:0]  gmii_txd;
    logic        tx_busy;
    logic        tx_done;

    arp_tx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .arp_tx_en  (arp_tx_en),
        .arp_tx_type(arp_tx_type),
        .des_mac    (des_mac),
        .des_ip     (des_ip),
        .gmii_tx_en (gmii_tx_en),
        .gmii_txd   (gmii_txd),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    always #4 clk = ~clk;

    localparam logic [47:0] PEER_MAC = 48'h000A_3501_FEC0;
    localparam logic [31:0] PEER_IP  = {8'd192, 8'd168, 8'd1, 8'd102};

    int total = 0;
    int bad   = 0;

    logic [7:0] rx    [0:99];
    logic [7:0] rx1   [0:71];
    logic [7:0] exp_f [0:71];
    int         rx_len;
    int         busy_gap;
    logic       done_ok;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] crc_b(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    task automatic build(input bit rep, input logic [47:0] m, input logic [31:0] ip);
        logic [47:0] bmac;
        logic [31:0] bip;
        logic [31:0] c;
        bmac = 48'h00_11_22_33_44_55;
        bip  = 32'hC0A8_010A;
        for (int i = 0; i < 7; i++) exp_f[i] = 8'h55;
        exp_f[7] = 8'hD5;
        for (int k = 0; k < 6; k++) begin
            exp_f[8 + k]  = rep ? m[47 - 8*k -: 8] : 8'hFF;
            exp_f[14 + k] = bmac[47 - 8*k -: 8];
            exp_f[30 + k] = bmac[47 - 8*k -: 8];
            exp_f[40 + k] = rep ? m[47 - 8*k -: 8] : 8'h00;
        end
        exp_f[20] = 8'h08; exp_f[21] = 8'h06;
        exp_f[22] = 8'h00; exp_f[23] = 8'h01; exp_f[24] = 8'h08; exp_f[25] = 8'h00;
        exp_f[26] = 8'h06; exp_f[27] = 8'h04; exp_f[28] = 8'h00; exp_f[29] = rep ? 8'h02 : 8'h01;
        for (int k = 0; k < 4; k++) begin
            exp_f[36 + k] = bip[31 - 8*k -: 8];
            exp_f[46 + k] = ip[31 - 8*k -: 8];
        end
        for (int i = 50; i < 68; i++) exp_f[i] = 8'h00;
        c = 32'hFFFF_FFFF;
        for (int i = 8; i < 68; i++) c = crc_b(c, exp_f[i]);
        c = ~c;
        for (int k = 0; k < 4; k++) exp_f[68 + k] = c[8*k +: 8];
    endtask

    task automatic kick(input bit typ, input logic [47:0] m, input logic [31:0] ip);
        @(negedge clk);
        arp_tx_type = typ; des_mac = m; des_ip = ip; arp_tx_en = 1'b1;
        @(negedge clk);
        arp_tx_en = 1'b0;
    endtask

    // Collect one frame from the negedge samples; returns at the cycle after the last byte
    task automatic capture();
        int t;
        t = 0; rx_len = 0; busy_gap = 0; done_ok = 1'b0;
        while (!gmii_tx_en && t < 50) begin @(negedge clk); t++; end
        if (!gmii_tx_en) begin
            chk("frame_timeout", 0, 1);
            return;
        end
        while (gmii_tx_en && rx_len < 100) begin
            rx[rx_len] = gmii_txd;
            if (!tx_busy) busy_gap++;
            rx_len++;
            @(negedge clk);
        end
        done_ok = tx_done && (gmii_txd == 8'h00) && tx_busy;
    endtask

    task automatic check_frame(input string tag);
        int m;
        logic [31:0] c, rv;
        m = 0;
        chk({tag, "_len"}, rx_len, 72);
        for (int i = 0; i < 72; i++) if (rx[i] !== exp_f[i]) m++;
        chk({tag, "_bytes"}, m, 0);
        chk({tag, "_fcs"}, {rx[68], rx[69], rx[70], rx[71]}, {exp_f[68], exp_f[69], exp_f[70], exp_f[71]});
        c = 32'hFFFF_FFFF;
        for (int i = 8; i < 72; i++) c = crc_b(c, rx[i]);
        for (int i = 0; i < 32; i++) rv[i] = c[31 - i];
        chk({tag, "_residue"}, rv, 32'hC704_DD7B);
        chk({tag, "_done"}, done_ok, 1);
    endtask

    initial begin
        int n, hi, gap;
        bit pulsed;

        #1;
        chk("rst_tx_en", gmii_tx_en, 0);
        chk("rst_txd", gmii_txd, 8'h00);
        chk("rst_busy_done", {tx_busy, tx_done}, 2'b00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: request
        build(1'b0, '0, PEER_IP);
        kick(1'b0, 48'h0, PEER_IP);
        chk("req_latency", {gmii_tx_en, gmii_txd}, {1'b1, 8'h55});
        capture();
        check_frame("req");
        chk("req_dst", {rx[8], rx[9], rx[10], rx[11], rx[12], rx[13]}, 48'hFFFF_FFFF_FFFF);
        chk("req_op", {rx[28], rx[29]}, 16'h0001);
        chk("req_tmac", {rx[40], rx[41], rx[42], rx[43], rx[44], rx[45]}, 48'h0);
        chk("req_tip", {rx[46], rx[47], rx[48], rx[49]}, 32'hC0A8_0166);
        for (int i = 0; i < 72; i++) rx1[i] = rx[i];
        repeat (20) @(negedge clk);

        // 2: reply
        build(1'b1, PEER_MAC, PEER_IP);
        kick(1'b1, PEER_MAC, PEER_IP);
        capture();
        check_frame("rep");
        chk("rep_dst", {rx[8], rx[9], rx[10], rx[11], rx[12], rx[13]}, 48'h000A_3501_FEC0);
        chk("rep_tmac", {rx[40], rx[41], rx[42], rx[43], rx[44], rx[45]}, 48'h000A_3501_FEC0);
        chk("rep_op", {rx[28], rx[29]}, 16'h0002);
        repeat (20) @(negedge clk);

        // 3: extra starts while busy are dropped
        build(1'b0, '0, PEER_IP);
        kick(1'b0, 48'h0, PEER_IP);
        fork
            capture();
            begin
                repeat (19) @(negedge clk);
                arp_tx_en = 1'b1;
                @(negedge clk);
                arp_tx_en = 1'b0;
            end
        join
        check_frame("ign");
        chk("ign_busy_frame", busy_gap, 0);
        n = 0;
        while (tx_busy && n < 50) begin
            arp_tx_en = (n == 5);
            n++;
            @(negedge clk);
        end
        arp_tx_en = 1'b0;
        chk("ign_ifg_busy", n, 12);
        hi = 0;
        repeat (30) begin @(negedge clk); if (gmii_tx_en || tx_busy) hi++; end
        chk("ign_no_queue", hi, 0);

        // 4: inputs changed mid-frame do not leak into the frame
        build(1'b1, PEER_MAC, PEER_IP);
        kick(1'b1, PEER_MAC, PEER_IP);
        des_mac = 48'hDEAD_BEEF_0001;
        des_ip  = 32'h0A00_0001;
        arp_tx_type = 1'b0;
        capture();
        check_frame("latch");
        repeat (20) @(negedge clk);

        // 5: reset during ARP_DATA
        kick(1'b0, 48'h0, PEER_IP);
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out", {gmii_tx_en, tx_busy, gmii_txd}, 10'h000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        hi = 0;
        repeat (20) begin @(negedge clk); if (gmii_tx_en) hi++; end
        chk("post_rst_quiet", hi, 0);
        build(1'b0, '0, PEER_IP);
        kick(1'b0, 48'h0, PEER_IP);
        capture();
        check_frame("rst");
        n = 0;
        for (int i = 0; i < 72; i++) if (rx[i] !== rx1[i]) n++;
        chk("rst_same_as_req", n, 0);

        // 6: back-to-back at the first idle cycle
        gap = 0; pulsed = 1'b0;
        while (!gmii_tx_en && gap < 60) begin
            if (!tx_busy && !pulsed) begin arp_tx_en = 1'b1; pulsed = 1'b1; end
            else arp_tx_en = 1'b0;
            gap++;
            @(negedge clk);
        end
        arp_tx_en = 1'b0;
        chk("b2b_gap", gap, 13);
        capture();
        check_frame("b2b");

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
